// File: rtl/noc_pkg.sv
// Shared types, widths and routing helpers for the mesh router control path.
package noc_pkg;

  localparam int unsigned NUM_PORTS = 5;
  localparam int unsigned PORT_W    = 3;
  localparam int unsigned FLIT_W    = 32;
  localparam int unsigned ADDR_W    = 16;
  localparam int unsigned SIZE_W    = 16;

  typedef enum logic [PORT_W-1:0] {
    EAST  = 3'd0,
    WEST  = 3'd1,
    NORTH = 3'd2,
    SOUTH = 3'd3,
    LOCAL = 3'd4
  } port_t;

  typedef enum logic [1:0] {S_IDLE, S_ARB, S_ROUTE, S_ACK} sc_state_t;

  typedef enum logic [1:0] {P_HDR, P_SIZE, P_PAY} rc_phase_t;

  // Dimension-ordered routing: resolve X first, then Y, else deliver locally.
  function automatic port_t xy_route(input logic [ADDR_W-1:0] target,
                                     input logic [ADDR_W-1:0] local_addr);
    port_t dir;
    if (target[15:8] > local_addr[15:8]) begin
      dir = EAST;
    end else if (target[15:8] < local_addr[15:8]) begin
      dir = WEST;
    end else if (target[7:0] > local_addr[7:0]) begin
      dir = NORTH;
    end else if (target[7:0] < local_addr[7:0]) begin
      dir = SOUTH;
    end else begin
      dir = LOCAL;
    end
    return dir;
  endfunction

  // First requester strictly after the last served index, wrapping mod NUM_PORTS.
  function automatic logic [PORT_W-1:0] rr_pick(input logic [NUM_PORTS-1:0] req,
                                                input logic [PORT_W-1:0]    last);
    logic [PORT_W-1:0] pick;
    logic              found;
    int unsigned       idx;
    pick  = PORT_W'((32'(last) + 32'd1) % NUM_PORTS);
    found = 1'b0;
    for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
      idx = (32'(last) + k) % NUM_PORTS;
      if (!found && req[PORT_W'(idx)]) begin
        pick  = PORT_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/output_release_counter.sv
// Tracks the packet leaving one output (header, size, payload) and flags the
// handshake that carries its last flit.
module output_release_counter
  import noc_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              busy_i,
  input  logic              hs_i,
  input  logic [SIZE_W-1:0] size_i,
  output logic              release_o
);

  rc_phase_t         phase_q, phase_d;
  logic [SIZE_W-1:0] cnt_q, cnt_d;

  always_comb begin
    phase_d   = phase_q;
    cnt_d     = cnt_q;
    release_o = 1'b0;
    // An idle output ignores traffic and waits for the next header.
    if (!busy_i) begin
      phase_d = P_HDR;
    end else if (hs_i) begin
      unique case (phase_q)
        P_HDR: begin
          phase_d = P_SIZE;
        end
        P_SIZE: begin
          cnt_d = size_i;
          if (size_i == '0) begin
            release_o = 1'b1;
            phase_d   = P_HDR;
          end else begin
            phase_d = P_PAY;
          end
        end
        P_PAY: begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == SIZE_W'(1)) begin
            release_o = 1'b1;
            phase_d   = P_HDR;
          end
        end
        default: begin
          phase_d = P_HDR;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      phase_q <= P_HDR;
      cnt_q   <= '0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/switch_control.sv
// Header arbitration and crossbar connection control for one 5-port mesh router:
// round-robin over input headers, XY routing, grant, and release after the last flit.
module switch_control
  import noc_pkg::*;
#(
  parameter logic [ADDR_W-1:0] ROUTER_ADDR = 16'h0000,
  parameter int unsigned       FLIT_W      = noc_pkg::FLIT_W
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [NUM_PORTS-1:0]                 h_req_i,
  input  logic [NUM_PORTS-1:0][FLIT_W-1:0]     header_i,
  output logic [NUM_PORTS-1:0]                 h_ack_o,
  output logic [NUM_PORTS-1:0]                 free_o,
  output logic [NUM_PORTS-1:0][PORT_W-1:0]     mux_in_o,
  output logic [NUM_PORTS-1:0][PORT_W-1:0]     mux_out_o,
  input  logic [NUM_PORTS-1:0]                 tx_i,
  input  logic [NUM_PORTS-1:0]                 credit_i,
  input  logic [NUM_PORTS-1:0][FLIT_W-1:0]     data_out_i
);

  sc_state_t                        state_q, state_d;
  logic [PORT_W-1:0]                sel_q, sel_d;
  logic [PORT_W-1:0]                last_q, last_d;
  logic [NUM_PORTS-1:0]             h_ack_q, h_ack_d;
  logic [NUM_PORTS-1:0]             free_q, free_d;
  logic [NUM_PORTS-1:0][PORT_W-1:0] mux_in_q, mux_in_d;
  logic [NUM_PORTS-1:0][PORT_W-1:0] mux_out_q, mux_out_d;

  logic [NUM_PORTS-1:0] release_vec;
  port_t                route_out;
  logic                 unused_hi_bits;

  // Only the address and size fields of the flits matter here.
  assign unused_hi_bits = ^{header_i, data_out_i};

  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_rel
    output_release_counter u_rel (
      .clock     (clock),
      .reset     (reset),
      .busy_i    (~free_q[o]),
      .hs_i      (tx_i[o] & credit_i[o]),
      .size_i    (data_out_i[o][SIZE_W-1:0]),
      .release_o (release_vec[o])
    );
  end

  assign route_out = xy_route(header_i[sel_q][ADDR_W-1:0], ROUTER_ADDR);

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    last_d    = last_q;
    h_ack_d   = '0;
    free_d    = free_q;
    mux_in_d  = mux_in_q;
    mux_out_d = mux_out_q;

    // Releases are applied first so a same-cycle grant to the same input wins.
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (release_vec[o]) begin
        free_d[o]                = 1'b1;
        mux_out_d[mux_in_q[o]] = '0;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (|h_req_i) begin
          state_d = S_ARB;
        end
      end
      S_ARB: begin
        sel_d   = rr_pick(h_req_i, last_q);
        state_d = S_ROUTE;
      end
      S_ROUTE: begin
        if (free_q[route_out]) begin
          free_d[route_out]    = 1'b0;
          mux_in_d[route_out]  = sel_q;
          mux_out_d[sel_q]     = route_out;
          h_ack_d[sel_q]       = 1'b1;
          state_d              = S_ACK;
        end else begin
          // A blocked request gives up its turn so others are not starved.
          last_d  = sel_q;
          state_d = S_IDLE;
        end
      end
      S_ACK: begin
        last_d  = sel_q;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      sel_q     <= '0;
      last_q    <= PORT_W'(NUM_PORTS - 1);
      h_ack_q   <= '0;
      free_q    <= '1;
      mux_in_q  <= '0;
      mux_out_q <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      h_ack_q   <= h_ack_d;
      free_q    <= free_d;
      mux_in_q  <= mux_in_d;
      mux_out_q <= mux_out_d;
    end
  end

  assign h_ack_o   = h_ack_q;
  assign free_o    = free_q;
  assign mux_in_o  = mux_in_q;
  assign mux_out_o = mux_out_q;

endmodule

// File: tb/tb_switch_control.sv
// Directed bench for switch_control at router address 0x0101.
module tb_switch_control;

  logic             clock = 1'b0;
  logic             reset;
  logic [4:0]       h_req;
  logic [4:0][31:0] header;
  logic [4:0]       h_ack;
  logic [4:0]       free;
  logic [4:0][2:0]  mux_in;
  logic [4:0][2:0]  mux_out;
  logic [4:0]       tx;
  logic [4:0]       credit;
  logic [4:0][31:0] data_out;

  int n_cmp  = 0;
  int n_fail = 0;

  switch_control #(
    .ROUTER_ADDR (16'h0101),
    .FLIT_W      (32)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .h_req_i    (h_req),
    .header_i   (header),
    .h_ack_o    (h_ack),
    .free_o     (free),
    .mux_in_o   (mux_in),
    .mux_out_o  (mux_out),
    .tx_i       (tx),
    .credit_i   (credit),
    .data_out_i (data_out)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_ack(input int bound, output int lat, output logic [4:0] ack);
    logic done;
    lat  = -1;
    ack  = '0;
    done = 1'b0;
    for (int c = 1; c <= bound; c++) begin
      if (!done) begin
        step();
        if (h_ack !== 5'b0) begin
          lat  = c;
          ack  = h_ack;
          done = 1'b1;
        end
      end
    end
  endtask

  // Raise a request, wait for its grant, drop the request; returns in the ack cycle.
  task automatic request(input int p, input logic [15:0] tgt, output int lat,
                         output logic [4:0] ack);
    header[p] = {16'h0, tgt};
    h_req[p]  = 1'b1;
    wait_ack(20, lat, ack);
    h_req[p]  = 1'b0;
  endtask

  task automatic flit(input int o, input logic cr, input logic [15:0] d);
    tx[o]       = 1'b1;
    credit[o]   = cr;
    data_out[o] = {16'h0, d};
    step();
    tx[o]       = 1'b0;
    credit[o]   = 1'b0;
    data_out[o] = '0;
  endtask

  task automatic test_reset();
    int acks;
    reset    = 1'b0;
    h_req    = '0;
    header   = '0;
    tx       = '0;
    credit   = '0;
    data_out = '0;
    repeat (3) @(posedge clock);
    #1;
    n_cmp++;
    if (free !== 5'b11111) begin
      n_fail++; $display("FAIL reset_free_during: got %b want 11111", free);
    end
    reset = 1'b1;
    step();
    n_cmp++;
    if (free !== 5'b11111) begin
      n_fail++; $display("FAIL reset_free: got %b want 11111", free);
    end
    n_cmp++;
    if (h_ack !== 5'b0) begin
      n_fail++; $display("FAIL reset_ack: got %b want 00000", h_ack);
    end
    n_cmp++;
    if (mux_in !== 15'h0 || mux_out !== 15'h0) begin
      n_fail++; $display("FAIL reset_mux: got in=%h out=%h want 0/0", mux_in, mux_out);
    end
    acks = 0;
    repeat (20) begin
      step();
      if (h_ack !== 5'b0) acks++;
    end
    n_cmp++;
    if (acks !== 0) begin
      n_fail++; $display("FAIL idle_no_ack: got %0d acks want 0", acks);
    end
  endtask

  task automatic test_latency();
    int         lat;
    logic [4:0] ack;
    request(4, 16'h0301, lat, ack);
    n_cmp++;
    if (lat !== 3) begin
      n_fail++; $display("FAIL lat_east: got %0d want 3", lat);
    end
    n_cmp++;
    if (ack !== 5'b10000) begin
      n_fail++; $display("FAIL ack_east: got %b want 10000", ack);
    end
    n_cmp++;
    if (free !== 5'b11110) begin
      n_fail++; $display("FAIL free_east: got %b want 11110", free);
    end
    n_cmp++;
    if (mux_in[0] !== 3'd4) begin
      n_fail++; $display("FAIL mux_in_east: got %0d want 4", mux_in[0]);
    end
    step();
    n_cmp++;
    if (h_ack !== 5'b0) begin
      n_fail++; $display("FAIL ack_pulse_width: got %b want 00000", h_ack);
    end
  endtask

  task automatic test_release();
    int         lat;
    logic [4:0] ack;
    flit(0, 1'b1, 16'h0301);
    n_cmp++;
    if (free[0] !== 1'b0) begin
      n_fail++; $display("FAIL rel_after_hdr: got %b want 0", free[0]);
    end
    flit(0, 1'b0, 16'h0002);
    flit(0, 1'b1, 16'h0002);
    flit(0, 1'b1, 16'h1111);
    n_cmp++;
    if (free !== 5'b11110) begin
      n_fail++; $display("FAIL rel_after_pay1: got %b want 11110", free);
    end
    flit(0, 1'b1, 16'h2222);
    n_cmp++;
    if (free !== 5'b11111) begin
      n_fail++; $display("FAIL rel_after_pay2: got %b want 11111", free);
    end
    // Stray handshake on an idle output must not advance its counter.
    flit(1, 1'b1, 16'h0000);
    request(4, 16'h0001, lat, ack);
    n_cmp++;
    if (ack !== 5'b10000) begin
      n_fail++; $display("FAIL ack_west: got %b want 10000", ack);
    end
    step();
    flit(1, 1'b1, 16'h0000);
    n_cmp++;
    if (free !== 5'b11101) begin
      n_fail++; $display("FAIL stray_hs_ignored: got %b want 11101", free);
    end
    flit(1, 1'b1, 16'h0000);
    n_cmp++;
    if (free !== 5'b11111) begin
      n_fail++; $display("FAIL rel_size0: got %b want 11111", free);
    end
  endtask

  task automatic test_xy_routes();
    logic [15:0] tgts [4];
    logic [2:0]  outs [4];
    logic [4:0]  exp_free;
    int          lat;
    logic [4:0]  ack;
    tgts = '{16'h0001, 16'h0102, 16'h0100, 16'h0101};
    outs = '{3'd1, 3'd2, 3'd3, 3'd4};
    for (int i = 0; i < 4; i++) begin
      exp_free          = 5'b11111;
      exp_free[outs[i]] = 1'b0;
      request(4, tgts[i], lat, ack);
      n_cmp++;
      if (lat !== 3 || ack !== 5'b10000) begin
        n_fail++; $display("FAIL xy_ack_%h: got lat=%0d ack=%b want 3/10000", tgts[i], lat, ack);
      end
      n_cmp++;
      if (free !== exp_free) begin
        n_fail++; $display("FAIL xy_free_%h: got %b want %b", tgts[i], free, exp_free);
      end
      n_cmp++;
      if (mux_in[outs[i]] !== 3'd4 || mux_out[4] !== outs[i]) begin
        n_fail++; $display("FAIL xy_mux_%h: got in=%0d out=%0d want 4/%0d",
                           tgts[i], mux_in[outs[i]], mux_out[4], outs[i]);
      end
      step();
      flit(int'(outs[i]), 1'b1, 16'h0000);
      flit(int'(outs[i]), 1'b1, 16'h0000);
      n_cmp++;
      if (free !== 5'b11111 || mux_out[4] !== 3'd0) begin
        n_fail++; $display("FAIL xy_release_%h: got free=%b mux_out4=%0d want 11111/0",
                           tgts[i], free, mux_out[4]);
      end
    end
  endtask

  task automatic test_contention();
    int         lat;
    int         acks;
    logic [4:0] ack;
    header[1] = 32'h0000_0301;
    header[2] = 32'h0000_0301;
    h_req     = 5'b00110;
    wait_ack(20, lat, ack);
    n_cmp++;
    if (lat !== 3 || ack !== 5'b00010) begin
      n_fail++; $display("FAIL cont_first: got lat=%0d ack=%b want 3/00010", lat, ack);
    end
    n_cmp++;
    if (mux_in[0] !== 3'd1) begin
      n_fail++; $display("FAIL cont_mux_in1: got %0d want 1", mux_in[0]);
    end
    h_req[1] = 1'b0;
    acks = 0;
    repeat (15) begin
      step();
      if (h_ack !== 5'b0) acks++;
    end
    n_cmp++;
    if (acks !== 0 || free !== 5'b11110) begin
      n_fail++; $display("FAIL cont_blocked: got acks=%0d free=%b want 0/11110", acks, free);
    end
    flit(0, 1'b1, 16'h0000);
    flit(0, 1'b1, 16'h0000);
    wait_ack(20, lat, ack);
    h_req[2] = 1'b0;
    n_cmp++;
    if (ack !== 5'b00100 || mux_in[0] !== 3'd2 || free !== 5'b11110) begin
      n_fail++; $display("FAIL cont_retry: got ack=%b mux_in0=%0d free=%b want 00100/2/11110",
                         ack, mux_in[0], free);
    end
    step();
    flit(0, 1'b1, 16'h0000);
    flit(0, 1'b1, 16'h0000);
    n_cmp++;
    if (free !== 5'b11111) begin
      n_fail++; $display("FAIL cont_release: got %b want 11111", free);
    end
  endtask

  task automatic test_back_to_back();
    int         lat1;
    int         lat2;
    logic [4:0] ack1;
    logic [4:0] ack2;
    lat1      = -1;
    lat2      = -1;
    ack1      = '0;
    ack2      = '0;
    header[0] = 32'h0000_0001;
    header[3] = 32'h0000_0102;
    h_req     = 5'b01001;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (h_ack !== 5'b0) begin
        if (lat1 < 0) begin
          lat1 = c;
          ack1 = h_ack;
        end else begin
          lat2 = c;
          ack2 = h_ack;
        end
        h_req = h_req & ~h_ack;
      end
    end
    n_cmp++;
    if (lat1 !== 3 || ack1 !== 5'b01000) begin
      n_fail++; $display("FAIL b2b_first: got lat=%0d ack=%b want 3/01000", lat1, ack1);
    end
    n_cmp++;
    if (lat2 !== 7 || ack2 !== 5'b00001) begin
      n_fail++; $display("FAIL b2b_second: got lat=%0d ack=%b want 7/00001", lat2, ack2);
    end
    n_cmp++;
    if (free !== 5'b11001 || mux_out[0] !== 3'd1 || mux_out[3] !== 3'd2) begin
      n_fail++; $display("FAIL b2b_conn: got free=%b mo0=%0d mo3=%0d want 11001/1/2",
                         free, mux_out[0], mux_out[3]);
    end
    h_req    = '0;
    tx       = 5'b00110;
    credit   = 5'b00110;
    data_out = '0;
    step();
    step();
    tx     = '0;
    credit = '0;
    n_cmp++;
    if (free !== 5'b11111 || mux_out !== 15'h0) begin
      n_fail++; $display("FAIL b2b_release: got free=%b mux_out=%h want 11111/0", free, mux_out);
    end
  endtask

  task automatic test_reset_mid_payload();
    int         lat;
    logic [4:0] ack;
    request(4, 16'h0301, lat, ack);
    step();
    flit(0, 1'b1, 16'h0301);
    flit(0, 1'b1, 16'h0005);
    flit(0, 1'b1, 16'hAAAA);
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (free !== 5'b11111 || mux_in !== 15'h0 || h_ack !== 5'b0) begin
      n_fail++; $display("FAIL midreset_async: got free=%b mux_in=%h ack=%b want 11111/0/00000",
                         free, mux_in, h_ack);
    end
    @(posedge clock);
    #1;
    reset = 1'b1;
    request(4, 16'h0100, lat, ack);
    n_cmp++;
    if (lat !== 3 || ack !== 5'b10000 || free !== 5'b10111) begin
      n_fail++; $display("FAIL midreset_regrant: got lat=%0d ack=%b free=%b want 3/10000/10111",
                         lat, ack, free);
    end
    n_cmp++;
    if (mux_in[3] !== 3'd4 || mux_out[4] !== 3'd3) begin
      n_fail++; $display("FAIL midreset_mux: got in3=%0d out4=%0d want 4/3", mux_in[3], mux_out[4]);
    end
    step();
    flit(3, 1'b1, 16'h0100);
    flit(3, 1'b1, 16'h0000);
    n_cmp++;
    if (free !== 5'b11111) begin
      n_fail++; $display("FAIL midreset_release: got %b want 11111", free);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_release();
    test_xy_routes();
    test_contention();
    test_back_to_back();
    test_reset_mid_payload();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
